fetch_d_queue: RTL and testbench
================================

# fetch_D_queue

Parametrised successor to the single-entry fetch-to-decode pipeline register in the Y86-64 pipelined CPU. It holds up to DEPTH fetched instructions with their PC in a circular buffer between the fetch stage and decode. A valid/ready handshake lets fetch run ahead of a stalled decode. It keeps the D-stage stall/bubble semantics, adds an occupancy count, and closes intake after a non-AOK fetch status.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), width of count_o
- clk_i  in  1  rising-edge clock
- rst_i  in  1  synchronous active-high reset
- f_valid_i  in  1  fetch presents an instruction this cycle
- f_ready_o  out  1  queue accepts an instruction this cycle
- f_stat_i  in  3  fetch status
- f_pc_i  in  64  instruction PC
- f_icode_i / f_ifun_i / f_rA_i / f_rB_i  in  4 each  decoded fields
- f_valC_i / f_valP_i  in  64 each  constant word and next PC
- D_stall_i  in  1  decode holds the current head entry
- D_bubble_i  in  1  flush every entry and present a bubble
- D_valid_o  out  1  head entry is real (queue non-empty)
- D_stat_o, D_pc_o, D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o  out  widths as f_*  head entry fields
- count_o  out  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH entries of 3+64+4·4+64+64 = 211 bits, plus write pointer wp, read pointer rp (log2 DEPTH bits, wrap modulo DEPTH), a count register and a lock flag.
- Enqueue: occurs when f_valid_i && f_ready_o. Writes the entry at wp and increments wp.
- f_ready_o = !rst_i && (count < DEPTH) && !lock. There is no full-and-dequeue bypass: when full, ready stays 0 even if a dequeue happens that cycle.
- Dequeue: occurs when D_valid_o && !D_stall_i && !D_bubble_i. Increments rp.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- D_* outputs show the entry at rp whenever count > 0.
- When count == 0, D_* outputs show bubble values: stat = SAOK (3'd1), pc = 0, icode = INOP (4'h1), ifun = 0, rA = rB = RNONE (4'hF), valC = valP = 0, and D_valid_o = 0.
- Bubble (D_bubble_i = 1): next cycle wp = rp = 0, count = 0, lock = 0. Any enqueue in the same cycle is dropped because bubble has priority over enqueue. D_stall_i is ignored while D_bubble_i is high.
- Lock: enqueuing an entry with f_stat_i != SAOK (HLT, ADR, INS) sets lock. While lock is set, f_ready_o = 0. Entries already queued, including the faulting one, still drain normally. Lock clears only on bubble or reset.
- Stall with an empty queue: no effect; bubble values stay on D_*.
- All outputs are driven by flops plus the head mux. There is no combinational path from any f_*_i data input to any D_* output.

## Timing
- Reset: on a rising edge with rst_i = 1, all pointers, count and lock go to 0. Next cycle D_valid_o = 0, D_* show bubble values and count_o = 0. f_ready_o is 0 during the reset cycle and 1 in the cycle after.
- Reset mid-operation discards all entries, with the same result as power-up.
- Enqueue latency: an instruction accepted at edge N is visible on D_* after edge N when the queue was empty (one cycle, same as the old register).
- Throughput: one enqueue and one dequeue per cycle sustained. Order is strict FIFO.
- count_o updates on the same edge as the pointers.
- Pointer wrap: after DEPTH enqueues wp returns to 0. Order is preserved across the wrap.

## Test plan
- Reset then stream: rst_i 2 cycles, then 6 instructions with PC 10, 20, …, 60, no stall → D_pc_o = 10..60 on consecutive cycles, each one cycle after its enqueue, and count_o never exceeds 1.
- Fill: D_stall_i = 1, offer 6 instructions with DEPTH = 4 → 4 accepted, then f_ready_o = 0 and count_o = 4. D_pc_o holds 10 throughout. Release stall → 10, 20, 30, 40 drain, and ready returns after the first dequeue.
- Wrap: 3 in, 2 out, then 4 in, continuously checked → output PC sequence equals input sequence, and count_o matches a reference model each cycle.
- Bubble: queue holds 3 entries, D_bubble_i = 1 together with f_valid_i = 1 → next cycle count_o = 0, D_valid_o = 0, D_icode_o = 4'h1, D_rA_o = 4'hF, and the concurrent instruction is not stored.
- Lock: enqueue PC 30 with f_stat_i = HLT → f_ready_o = 0 from the next cycle. PC 30 still reaches D_* with stat HLT. After a bubble, f_ready_o = 1.
- Reset mid-fill with 2 entries queued → next cycle count_o = 0, D_valid_o = 0, bubble values on D_*.

Source files
------------

// File: rtl/fetch_d_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry circular buffer with a
// valid/ready intake, D-stage stall/bubble control and a fault-status intake lock.
module fetch_d_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             f_valid_i,
    output logic             f_ready_o,
    input  logic [2:0]       f_stat_i,
    input  logic [63:0]      f_pc_i,
    input  logic [3:0]       f_icode_i,
    input  logic [3:0]       f_ifun_i,
    input  logic [3:0]       f_rA_i,
    input  logic [3:0]       f_rB_i,
    input  logic [63:0]      f_valC_i,
    input  logic [63:0]      f_valP_i,
    input  logic             D_stall_i,
    input  logic             D_bubble_i,
    output logic             D_valid_o,
    output logic [2:0]       D_stat_o,
    output logic [63:0]      D_pc_o,
    output logic [3:0]       D_icode_o,
    output logic [3:0]       D_ifun_o,
    output logic [3:0]       D_rA_o,
    output logic [3:0]       D_rB_o,
    output logic [63:0]      D_valC_o,
    output logic [63:0]      D_valP_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [2:0] SAOK  = 3'd1;
    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             lock_q, lock_d;
    logic             enq, deq;

    // Ready deliberately ignores a same-cycle dequeue: no full-and-drain bypass.
    assign f_ready_o = !rst_i && (count_q < FULL) && !lock_q;
    assign D_valid_o = (count_q != '0);
    assign enq       = f_valid_i && f_ready_o && !D_bubble_i;
    assign deq       = D_valid_o && !D_stall_i && !D_bubble_i;

    assign wr_entry = '{stat: f_stat_i, pc: f_pc_i, icode: f_icode_i, ifun: f_ifun_i,
                        rA: f_rA_i, rB: f_rB_i, valC: f_valC_i, valP: f_valP_i};

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        lock_d  = lock_q;
        if (D_bubble_i) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            lock_d  = 1'b0;
        end else begin
            if (enq) begin
                wp_d = wp_q + 1'b1;
                if (f_stat_i != SAOK) lock_d = 1'b1;
            end
            if (deq) rp_d = rp_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            lock_q  <= lock_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wp_q] <= wr_entry;
    end

    // Head mux: stored entry when non-empty, otherwise a decode bubble.
    always_comb begin
        head = mem_q[rp_q];
        if (!D_valid_o) begin
            head = '{stat: SAOK, pc: '0, icode: INOP, ifun: '0,
                     rA: RNONE, rB: RNONE, valC: '0, valP: '0};
        end
    end

    assign D_stat_o  = head.stat;
    assign D_pc_o    = head.pc;
    assign D_icode_o = head.icode;
    assign D_ifun_o  = head.ifun;
    assign D_rA_o    = head.rA;
    assign D_rB_o    = head.rB;
    assign D_valC_o  = head.valC;
    assign D_valP_o  = head.valP;
    assign count_o   = count_q;

endmodule

// File: tb/tb_fetch_d_queue.sv
// Self-checking bench for fetch_d_queue: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_fetch_d_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [2:0]  stat;
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
    } ent_t;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             f_valid_i = 1'b0;
    logic             f_ready_o;
    logic [2:0]       f_stat_i = 3'd1;
    logic [63:0]      f_pc_i = '0;
    logic [3:0]       f_icode_i = '0;
    logic [3:0]       f_ifun_i = '0;
    logic [3:0]       f_rA_i = '0;
    logic [3:0]       f_rB_i = '0;
    logic [63:0]      f_valC_i = '0;
    logic [63:0]      f_valP_i = '0;
    logic             D_stall_i = 1'b0;
    logic             D_bubble_i = 1'b0;
    logic             D_valid_o;
    logic [2:0]       D_stat_o;
    logic [63:0]      D_pc_o;
    logic [3:0]       D_icode_o;
    logic [3:0]       D_ifun_o;
    logic [3:0]       D_rA_o;
    logic [3:0]       D_rB_o;
    logic [63:0]      D_valC_o;
    logic [63:0]      D_valP_o;
    logic [CNT_W-1:0] count_o;

    always #5 clk_i = ~clk_i;

    fetch_d_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .f_valid_i(f_valid_i), .f_ready_o(f_ready_o),
        .f_stat_i(f_stat_i), .f_pc_i(f_pc_i), .f_icode_i(f_icode_i),
        .f_ifun_i(f_ifun_i), .f_rA_i(f_rA_i), .f_rB_i(f_rB_i),
        .f_valC_i(f_valC_i), .f_valP_i(f_valP_i),
        .D_stall_i(D_stall_i), .D_bubble_i(D_bubble_i),
        .D_valid_o(D_valid_o), .D_stat_o(D_stat_o), .D_pc_o(D_pc_o),
        .D_icode_o(D_icode_o), .D_ifun_o(D_ifun_o), .D_rA_o(D_rA_o),
        .D_rB_o(D_rB_o), .D_valC_o(D_valC_o), .D_valP_o(D_valP_o),
        .count_o(count_o)
    );

    ent_t q[$];
    bit   lock_m = 0;
    bit   known = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc_no = 0;

    function automatic ent_t bubble_ent();
        ent_t b;
        b.stat = 3'd1;  b.pc = '0;    b.icode = 4'h1; b.ifun = '0;
        b.rA = 4'hF;    b.rB = 4'hF;  b.valC = '0;    b.valP = '0;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d observed=%0h expected=%0h", tag, cyc_no, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs, advance the model, take the edge.
    task automatic cyc(input bit v, input bit st, input bit bb, input bit rs,
                       input logic [63:0] pc, input logic [2:0] stat);
        ent_t e, h, d;
        bit   exp_ready;
        e.stat = stat; e.pc = pc;
        e.icode = 4'($urandom); e.ifun = 4'($urandom);
        e.rA = 4'($urandom);    e.rB = 4'($urandom);
        e.valC = {$urandom, $urandom};
        e.valP = {$urandom, $urandom};
        rst_i = rs; f_valid_i = v; D_stall_i = st; D_bubble_i = bb;
        f_stat_i = e.stat; f_pc_i = e.pc; f_icode_i = e.icode; f_ifun_i = e.ifun;
        f_rA_i = e.rA; f_rB_i = e.rB; f_valC_i = e.valC; f_valP_i = e.valP;
        #1;
        exp_ready = !rs && known && (q.size() < DEPTH) && !lock_m;
        chk("ready", 256'(f_ready_o), 256'(exp_ready));
        if (known) begin
            h = (q.size() > 0) ? q[0] : bubble_ent();
            d = '{stat: D_stat_o, pc: D_pc_o, icode: D_icode_o, ifun: D_ifun_o,
                  rA: D_rA_o, rB: D_rB_o, valC: D_valC_o, valP: D_valP_o};
            chk("valid", 256'(D_valid_o), 256'(q.size() > 0));
            chk("count", 256'(count_o), 256'(q.size()));
            chk("head", 256'(d), 256'(h));
        end
        $display("cycle %0d rst=%0b v=%0b stall=%0b bub=%0b pc=%0d stat=%0d | ready=%0b valid=%0b D_pc=%0d D_stat=%0d count=%0d",
                 cyc_no, rs, v, st, bb, pc, stat, f_ready_o, D_valid_o, D_pc_o, D_stat_o, count_o);
        if (rs) begin
            q.delete(); lock_m = 0; known = 1;
        end else if (known) begin
            if (bb) begin
                q.delete(); lock_m = 0;
            end else begin
                if (q.size() > 0 && !st) void'(q.pop_front());
                if (v && exp_ready) begin
                    q.push_back(e);
                    if (stat != 3'd1) lock_m = 1;
                end
            end
        end
        @(posedge clk_i);
        #1;
        cyc_no++;
    endtask

    initial begin
        // Reset, then a non-stalled stream of 6
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        for (int i = 1; i <= 6; i++) cyc(1, 0, 0, 0, 64'(i * 10), 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("stream_empty", 256'(count_o), 256'(0));
        // Fill under stall, then drain
        for (int i = 1; i <= 6; i++) cyc(1, 1, 0, 0, 64'(i * 10), 1);
        chk("fill_count", 256'(count_o), 256'(DEPTH));
        chk("fill_head", 256'(D_pc_o), 256'(10));
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
        // Wrap: 3 in, 2 out, 4 in, drain
        for (int i = 1; i <= 3; i++) cyc(1, 1, 0, 0, 64'(100 + i), 1);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cyc(1, 1, 0, 0, 64'(200 + i), 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
        // Bubble with a concurrent enqueue
        for (int i = 1; i <= 3; i++) cyc(1, 1, 0, 0, 64'(300 + i), 1);
        cyc(1, 0, 1, 0, 399, 1);
        chk("bubble_icode", 256'(D_icode_o), 256'(4'h1));
        chk("bubble_rA", 256'(D_rA_o), 256'(4'hF));
        cyc(0, 1, 0, 0, 0, 1);
        // Lock on a halting fetch
        cyc(1, 1, 0, 0, 10, 1);
        cyc(1, 1, 0, 0, 20, 1);
        cyc(1, 1, 0, 0, 30, 2);
        chk("lock_ready", 256'(f_ready_o), 256'(0));
        cyc(1, 1, 0, 0, 40, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        chk("unlock_ready", 256'(f_ready_o), 256'(1));
        cyc(1, 0, 0, 0, 50, 1);
        // Reset with two entries queued
        cyc(1, 1, 0, 0, 60, 1);
        cyc(1, 1, 0, 1, 70, 1);
        cyc(0, 0, 0, 0, 0, 1);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 20) == 0,
                ($urandom % 60) == 0, {$urandom, $urandom},
                (($urandom % 12) == 0) ? 3'($urandom) : 3'd1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
